// File: rtl/hazard_pkg.sv
// Shared widths, types and default configuration for the ID/EX hazard scoreboard.
// Modules take their defaults from here so a pipeline variant changes one place.
package hazard_pkg;

  localparam int DEF_NREGS      = 32;
  localparam int DEF_MAX_LAT    = 4;
  localparam int DEF_FWD_STAGES = 2;

  localparam int REG_W = $clog2(DEF_NREGS);
  localparam int LAT_W = $clog2(DEF_MAX_LAT + 1);
  localparam int FWD_W = $clog2(DEF_FWD_STAGES + 1);

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;
  typedef logic [FWD_W-1:0] fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_history.sv
// Destination history of the last FWD_STAGES issue slots, plus a youngest-match
// priority encoder shared by the two EX operand sources.
module hazard_fwd_history
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [REG_W-1:0] push_rd,
  input  logic             rs_a_en,
  input  logic [REG_W-1:0] rs_a,
  input  logic             rs_b_en,
  input  logic [REG_W-1:0] rs_b,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b
);

  logic [FWD_STAGES:1] hist_valid;
  logic [REG_W-1:0]    hist_rd [FWD_STAGES:1];

  // The history advances every cycle; a cycle without issue pushes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= '0;
    end else begin
      hist_valid[1] <= push_valid;
      for (int k = 2; k <= FWD_STAGES; k++) hist_valid[k] <= hist_valid[k-1];
    end
  end

  // NOTE: only the valid bits need a reset; rd is never looked at while its entry is invalid.
  always_ff @(posedge clk) begin
    hist_rd[1] <= push_rd;
    for (int k = 2; k <= FWD_STAGES; k++) hist_rd[k] <= hist_rd[k-1];
  end

  // NOTE: defaults first so every path assigns the selects and no latch is inferred.
  always_comb begin
    sel_a = SEL_W'(FWD_REGFILE);
    sel_b = SEL_W'(FWD_REGFILE);
    // Scan oldest to youngest so the smallest matching stage wins.
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (rs_a_en && rs_a != '0 && hist_valid[k] && hist_rd[k] == rs_a) sel_a = SEL_W'(k);
      if (rs_b_en && rs_b != '0 && hist_valid[k] && hist_rd[k] == rs_b) sel_b = SEL_W'(k);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: per-register latency countdowns drive RAW/WAW stalls,
// and a short destination history yields registered EX forwarding selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS      = DEF_NREGS,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int FWD_STAGES = DEF_FWD_STAGES,
  // Set when every producer with latency beyond the forwarding window has
  // committed to the regfile within MAX_LAT+1 cycles.
  parameter bit REGFILE_COMMITS_IN_TIME = 1'b1,
  localparam int REG_BITS = $clog2(NREGS),
  localparam int CNT_BITS = $clog2(MAX_LAT + 1),
  localparam int SEL_BITS = $clog2(FWD_STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_rs1_use,
  input  logic                id_rs2_use,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_rd_wr,
  input  logic [CNT_BITS-1:0] id_lat,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [SEL_BITS-1:0] fwd_sel_a,
  output logic [SEL_BITS-1:0] fwd_sel_b
);

  if (MAX_LAT >= FWD_STAGES + 1 && !REGFILE_COMMITS_IN_TIME) begin : g_lat_check
    $error("hazard_scoreboard: MAX_LAT exceeds the forwarding window and producers do not commit in time");
  end

  logic [CNT_BITS-1:0] cnt [NREGS];
  logic                raw;
  logic                waw;
  logic                rd_load;
  logic [SEL_BITS-1:0] sel_a;
  logic [SEL_BITS-1:0] sel_b;

  // RAW looks at the pre-update counters, so "add x5,x5,x1" only waits on the older x5.
  assign raw = (id_rs1_use && id_rs1 != '0 && cnt[id_rs1] != '0)
            || (id_rs2_use && id_rs2 != '0 && cnt[id_rs2] != '0);
  // A younger write must not land before an older, slower one to the same rd.
  assign waw = id_rd_wr && id_rd != '0 && cnt[id_rd] > id_lat;

  assign stall   = id_valid && (raw || waw);
  assign issue   = id_valid && !stall && !flush;
  assign rd_load = issue && id_rd_wr && id_rd != '0;

  // NOTE: sequential state uses non-blocking assignments so every counter sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (rd_load && id_rd == REG_BITS'(r)) begin
          cnt[r] <= id_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  hazard_fwd_history #(
    .REG_W      (REG_BITS),
    .FWD_STAGES (FWD_STAGES),
    .SEL_W      (SEL_BITS)
  ) u_history (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rd_load),
    .push_rd    (id_rd),
    .rs_a_en    (id_rs1_use),
    .rs_a       (id_rs1),
    .rs_b_en    (id_rs2_use),
    .rs_b       (id_rs2),
    .sel_a      (sel_a),
    .sel_b      (sel_b)
  );

  // Selects are captured only for an issuing instruction; bubbles read the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_a <= SEL_BITS'(FWD_REGFILE);
      fwd_sel_b <= SEL_BITS'(FWD_REGFILE);
    end else begin
      fwd_sel_a <= issue ? sel_a : SEL_BITS'(FWD_REGFILE);
      fwd_sel_b <= issue ? sel_b : SEL_BITS'(FWD_REGFILE);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a per-cycle vector table with hand-derived stall/issue/select
// expectations, forwarding selects scored one cycle later through a queue.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     id_valid, id_rs1_use, id_rs2_use, id_rd_wr, flush;
  reg_idx_t id_rs1, id_rs2, id_rd;
  lat_t     id_lat;
  logic     stall, issue;
  fwd_sel_t fwd_sel_a, fwd_sel_b;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_use (id_rs1_use),
    .id_rs2_use (id_rs2_use),
    .id_rd      (id_rd),
    .id_rd_wr   (id_rd_wr),
    .id_lat     (id_lat),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b)
  );

  typedef struct {
    logic     valid;
    reg_idx_t rs1;
    logic     u1;
    reg_idx_t rs2;
    logic     u2;
    reg_idx_t rd;
    logic     wr;
    lat_t     lat;
    logic     flush;
    logic     stall;
    logic     issue;
    fwd_sel_t sa;
    fwd_sel_t sb;
  } vec_t;

  typedef struct {
    fwd_sel_t a;
    fwd_sel_t b;
  } sel_pair_t;

  vec_t      vecs[$];
  sel_pair_t exp_q[$];
  int        tests = 0;
  int        failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, r1, u1, r2, u2, rd, wr, lat, fl, st, is, sa, sb);
    vec_t t;
    t.valid = v[0];  t.rs1 = reg_idx_t'(r1); t.u1 = u1[0];
    t.rs2 = reg_idx_t'(r2); t.u2 = u2[0];   t.rd = reg_idx_t'(rd);
    t.wr = wr[0];    t.lat = lat_t'(lat);    t.flush = fl[0];
    t.stall = st[0]; t.issue = is[0];
    t.sa = fwd_sel_t'(sa); t.sb = fwd_sel_t'(sb);
    return t;
  endfunction

  // Fields: valid, rs1,use1, rs2,use2, rd,wr, lat, flush | stall, issue, next sel_a, sel_b.
  task automatic row(input int v, r1, u1, r2, u2, rd, wr, lat, fl, st, is, sa, sb);
    vecs.push_back(mk(v, r1, u1, r2, u2, rd, wr, lat, fl, st, is, sa, sb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.valid; id_rs1 = t.rs1; id_rs1_use = t.u1;
    id_rs2 = t.rs2;     id_rs2_use = t.u2;
    id_rd = t.rd;       id_rd_wr = t.wr; id_lat = t.lat; flush = t.flush;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_pair_t got;

    // Load-use with one bubble, then forward from stage 2.
    idle(4);
    row(1, 1,1, 0,0, 5,1, 1, 0,  0,1, 0,0);
    row(1, 5,1, 1,1, 6,1, 0, 0,  1,0, 0,0);
    row(1, 5,1, 1,1, 6,1, 0, 0,  0,1, 2,0);
    idle(4);
    // Back-to-back ALU: both operands from stage 1.
    row(1, 1,1, 2,1, 5,1, 0, 0,  0,1, 0,0);
    row(1, 5,1, 5,1, 7,1, 0, 0,  0,1, 1,1);
    idle(4);
    // Youngest producer wins; x0 source never forwards.
    row(1, 1,1, 2,1, 5,1, 0, 0,  0,1, 0,0);
    row(1, 1,1, 2,1, 5,1, 0, 0,  0,1, 0,0);
    row(1, 5,1, 0,1, 9,1, 0, 0,  0,1, 1,0);
    idle(4);
    // WAW behind a lat=3 multiply: three stall cycles.
    row(1, 1,1, 2,1, 8,1, 3, 0,  0,1, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  0,1, 0,0);
    idle(4);
    // WAW boundary: equal latency does not stall.
    row(1, 1,1, 2,1, 8,1, 3, 0,  0,1, 0,0);
    row(1, 1,1, 0,0, 8,1, 3, 0,  0,1, 0,0);
    idle(4);
    // RAW on rs2 lasting two cycles; producer then older than the window.
    row(1, 1,1, 0,0, 5,1, 2, 0,  0,1, 0,0);
    row(1, 1,1, 5,1, 6,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 5,1, 6,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 5,1, 6,1, 0, 0,  0,1, 0,0);
    idle(4);
    // Unused sources neither stall nor forward.
    row(1, 1,1, 0,0, 5,1, 1, 0,  0,1, 0,0);
    row(1, 5,0, 5,0, 6,1, 0, 0,  0,1, 0,0);
    idle(4);
    // Flush during a stall: countdown continues, nothing issues.
    row(1, 1,1, 2,1, 8,1, 3, 0,  0,1, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 1,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  1,0, 0,0);
    row(1, 1,1, 2,1, 8,1, 0, 0,  0,1, 0,0);
    // Flushed producer leaves no counter and no history entry.
    row(1, 1,1, 0,0, 3,1, 2, 1,  0,0, 0,0);
    row(1, 3,1, 0,1, 4,1, 0, 0,  0,1, 0,0);
    idle(4);
    // Writes to x0 are ignored.
    row(1, 1,1, 0,0, 0,1, 1, 0,  0,1, 0,0);
    row(1, 0,1, 0,1, 6,1, 0, 0,  0,1, 0,0);
    idle(2);
    // Invalid ID slot never stalls even with a live hazard.
    row(1, 1,1, 0,0, 5,1, 2, 0,  0,1, 0,0);
    row(0, 5,1, 5,1, 6,1, 0, 0,  0,0, 0,0);
    row(1, 5,1, 0,0, 6,1, 0, 0,  1,0, 0,0);
    row(1, 5,1, 0,0, 6,1, 0, 0,  0,1, 0,0);
    idle(2);

    // Reset state.
    drive(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0));
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", stall, 0);
    check("reset issue", issue, 0);
    check("reset fwd_sel_a", fwd_sel_a, 0);
    check("reset fwd_sel_b", fwd_sel_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-operation reset drops the pending ld x5 and its history entry.
    drive(mk(1, 1,1, 0,0, 5,1, 1, 0, 0,0, 0,0));
    @(negedge clk);
    check("rst ld issue", issue, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    drive(mk(1, 5,1, 1,1, 6,1, 0, 0, 0,0, 0,0));
    check("rst held stall", stall, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst add stall", stall, 0);
    check("rst add issue", issue, 1);
    @(posedge clk);
    #1;
    check("rst add fwd_sel_a", fwd_sel_a, 0);
    check("rst add fwd_sel_b", fwd_sel_b, 0);

    // Table-driven run; selects are scored on the following cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d stall", i), stall, vecs[i].stall);
      check($sformatf("row%0d issue", i), issue, vecs[i].issue);
      exp_q.push_back('{a: vecs[i].sa, b: vecs[i].sb});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("row%0d queue", i), 0, 1);
      end else begin
        got = exp_q.pop_front();
        check($sformatf("row%0d fwd_sel_a", i), fwd_sel_a, got.a);
        check($sformatf("row%0d fwd_sel_b", i), fwd_sel_b, got.b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
